hex_switch_display: RTL and testbench

- Board-level top for the DE2-115 hex lab: samples the 18 slide switches and shows SW[15:0] as four hex digits on HEX3..HEX0, with HEX3 as the most significant digit.
- SW[17:16] is shown as one digit on HEX4.
- The raw switch state is mirrored onto the red LEDs.
- Drives the active-low seven-segment displays directly; no CPU involvement.

---
 rtl/hex_display_pkg.sv | 18 +
 rtl/hex_seven_seg.sv | 19 +
 rtl/hex_switch_display.sv | 93 +++++++++
 tb/tb_hex_switch_display.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Purpose : shared seven-segment types and the active-low hex glyph table.
// Contents: seg_t (bit0=a .. bit6=g, active low), SEG_BLANK, SEG_LUT[16].
// Used by : hex_seven_seg and hex_switch_display via import hex_display_pkg::*.
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Glyphs for 0..F; lower-case b and d keep them distinct from 8 and 0.
  localparam seg_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_seven_seg.sv
// Purpose : purely combinational nibble to active-low seven-segment decoder.
// Latency : zero cycles.
// Flow    : no handshake; the output follows the inputs continuously.
//
// Ports:
//   nibble [3:0] : value to display (0..F).
//   blank        : 1 forces the segments dark regardless of nibble.
//   seg    [6:0] : segments, active low, bit0=a .. bit6=g.
module hex_seven_seg
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg_t       seg
);

  assign seg = blank ? SEG_BLANK : SEG_LUT[nibble];

endmodule

// File: rtl/hex_switch_display.sv
// Purpose : DE2-115 board top; shows SW[15:0] on HEX3..HEX0, SW[17:16] on HEX4.
// Latency : one CLOCK_50 edge from SW to every output.
// Flow    : no backpressure; SW is sampled unconditionally every cycle.
//
// Ports:
//   CLOCK_50           : system clock, the only clock used.
//   rst                : synchronous active-high reset; clears the capture register.
//   CLOCK2_50/3_50, KEY: unused board inputs.
//   SW    [17:0]       : slide switches, assumed synchronous to CLOCK_50.
//   LEDG  [8:0]        : green LEDs, held at 0.
//   LEDR  [17:0]       : registered copy of SW.
//   HEX0..HEX7 [6:0]   : active-low segments; HEX5..HEX7 always blank.
//
// Build option: define HEX_LZB_EN for leading-zero blanking of HEX4..HEX1
// (HEX0 always shows its digit).
module hex_switch_display
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        CLOCK2_50,
  input  logic        CLOCK3_50,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output logic [8:0]  LEDG,
  output logic [17:0] LEDR,
  output seg_t        HEX0,
  output seg_t        HEX1,
  output seg_t        HEX2,
  output seg_t        HEX3,
  output seg_t        HEX4,
  output seg_t        HEX5,
  output seg_t        HEX6,
  output seg_t        HEX7
);

  logic [17:0] sw_q;
  logic [3:0]  digit [5];
  logic [4:0]  blank;
  seg_t        seg   [5];

  // Tie off board inputs this design has no use for.
  logic unused_inputs;
  assign unused_inputs = ^{CLOCK2_50, CLOCK3_50, KEY};

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sw_q <= '0;
    end else begin
      sw_q <= SW;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nibble
    assign digit[i] = sw_q[4*i +: 4];
  end
  // The two top switches form a fifth digit that can only show 0..3.
  assign digit[4] = {2'b00, sw_q[17:16]};

`ifdef HEX_LZB_EN
  // A digit goes dark only if it and every digit above it are zero.
  assign blank[4] = (digit[4] == 4'h0);
  assign blank[3] = blank[4] && (digit[3] == 4'h0);
  assign blank[2] = blank[3] && (digit[2] == 4'h0);
  assign blank[1] = blank[2] && (digit[1] == 4'h0);
  assign blank[0] = 1'b0;
`else
  assign blank = '0;
`endif

  for (genvar i = 0; i < 5; i++) begin : g_dec
    hex_seven_seg u_dec (
      .nibble (digit[i]),
      .blank  (blank[i]),
      .seg    (seg[i])
    );
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = SEG_BLANK;
  assign HEX6 = SEG_BLANK;
  assign HEX7 = SEG_BLANK;

  assign LEDR = sw_q;
  assign LEDG = '0;

endmodule

// File: tb/tb_hex_switch_display.sv
// Bench for hex_switch_display: drives SW/rst on the falling edge, checks all
// outputs 1 time unit after the rising edge against a reference model built
// from the display rules (digit = (q >> 4n) & 15, blanking from q >> 4n == 0).
module tb_hex_switch_display;

  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b1;
  logic        CLOCK2_50 = 1'b0;
  logic        CLOCK3_50 = 1'b0;
  logic [3:0]  KEY = 4'hF;
  logic [17:0] SW = '0;
  logic [8:0]  LEDG;
  logic [17:0] LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

  int total = 0;
  int bad   = 0;

  // Model of the capture register, advanced by the bench itself.
  logic [17:0] mq = '0;

  localparam logic [6:0] TB_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  always #10 CLOCK_50 = ~CLOCK_50;

  hex_switch_display #(.NUM_DIGITS(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .CLOCK2_50 (CLOCK2_50),
    .CLOCK3_50 (CLOCK3_50),
    .KEY       (KEY),
    .SW        (SW),
    .LEDG      (LEDG),
    .LEDR      (LEDR),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3),
    .HEX4      (HEX4),
    .HEX5      (HEX5),
    .HEX6      (HEX6),
    .HEX7      (HEX7)
  );

  // Expected {HEX7..HEX0, LEDR, LEDG} for a captured switch value q.
  function automatic logic [82:0] exp_vec(input logic [17:0] q);
    logic [6:0] h [8];
    for (int i = 0; i < 5; i++) begin
      h[i] = TB_LUT[int'((q >> (4 * i)) & 18'hF)];
`ifdef HEX_LZB_EN
      if (i >= 1 && (q >> (4 * i)) == 18'd0) h[i] = 7'h7F;
`endif
    end
    for (int i = 5; i < 8; i++) h[i] = 7'h7F;
    return {h[7], h[6], h[5], h[4], h[3], h[2], h[1], h[0], q, 9'd0};
  endfunction

  function automatic logic [82:0] obs();
    return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, LEDR, LEDG};
  endfunction

  // Apply inputs at the falling edge, advance one rising edge, update the model.
  task automatic drive(input logic r, input logic [17:0] s);
    @(negedge CLOCK_50);
    rst = r;
    SW  = s;
    @(posedge CLOCK_50);
    mq = r ? 18'd0 : s;
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 18'h3FFFF);
      total++;
      if (obs() !== exp_vec(18'd0)) begin
        bad++;
        $display("FAIL reset edge%0d: got %h want %h", k, obs(), exp_vec(18'd0));
      end
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v <= 256; v++) begin
      drive(1'b0, 18'(v));
      total++;
      if (obs() !== exp_vec(mq)) begin
        bad++;
        $display("FAIL sweep sw=%h: got %h want %h", v, obs(), exp_vec(mq));
      end
    end
  endtask

  task automatic test_patterns();
    logic [17:0] pat [4];
    pat[0] = 18'h0BEEF; pat[1] = 18'h3FFFF; pat[2] = 18'h00030; pat[3] = 18'h20000;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, pat[k]);
      total++;
      if (obs() !== exp_vec(pat[k])) begin
        bad++;
        $display("FAIL pattern %h: got %h want %h", pat[k], obs(), exp_vec(pat[k]));
      end
    end
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 18'($urandom));
      total++;
      if (obs() !== exp_vec(mq)) begin
        bad++;
        $display("FAIL random %h: got %h want %h", mq, obs(), exp_vec(mq));
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 18'h1234A);
    drive(1'b1, 18'h1234A);
    total++;
    if (obs() !== exp_vec(18'd0)) begin
      bad++;
      $display("FAIL mid_reset assert: got %h want %h", obs(), exp_vec(18'd0));
    end
    drive(1'b0, 18'h1234A);
    total++;
    if (obs() !== exp_vec(18'h1234A)) begin
      bad++;
      $display("FAIL mid_reset release: got %h want %h", obs(), exp_vec(18'h1234A));
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 18'h0FFFF);
    total++;
    if (obs() !== exp_vec(18'h0FFFF)) begin
      bad++;
      $display("FAIL wrap ffff: got %h want %h", obs(), exp_vec(18'h0FFFF));
    end
    @(negedge CLOCK_50);
    SW = 18'h00000;
    #1;
    total++;
    if (obs() !== exp_vec(18'h0FFFF)) begin
      bad++;
      $display("FAIL wrap early: got %h want %h", obs(), exp_vec(18'h0FFFF));
    end
    @(posedge CLOCK_50);
    #1;
    total++;
    if (obs() !== exp_vec(18'h00000)) begin
      bad++;
      $display("FAIL wrap zero: got %h want %h", obs(), exp_vec(18'h00000));
    end
  endtask

  task automatic test_back_to_back();
    logic r;
    for (int k = 0; k < 60; k++) begin
      r = ($urandom_range(0, 9) == 0);
      drive(r, 18'($urandom));
      total++;
      if (obs() !== exp_vec(mq)) begin
        bad++;
        $display("FAIL b2b step%0d rst=%0d: got %h want %h", k, r, obs(), exp_vec(mq));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_patterns();
    test_mid_reset();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
